mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32 from liang_pkg, data/address width.
REQ-002 SHALL have clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ifu_req_valid_i / ifu_req_ready_o  in/out  1  IFU request handshake.
REQ-005 SHALL have ifu_addr_i  input  XLEN  IFU fetch address; IFU requests are always reads.
REQ-006 SHALL have ifu_resp_valid_o  output  1 and ifu_rdata_o  output  XLEN  IFU response.
REQ-007 SHALL have lsu_req_valid_i / lsu_req_ready_o  in/out  1  LSU request handshake.
REQ-008 SHALL have lsu_addr_i  input  XLEN, lsu_wdata_i  input  XLEN, lsu_wmask_i  input  XLEN/8, lsu_wen_i  input  1  LSU request fields.
REQ-009 SHALL have lsu_resp_valid_o  output  1 and lsu_rdata_o  output  XLEN  LSU response.
REQ-010 SHALL have mem_req_valid_o / mem_req_ready_i  out/in  1  shared memory port handshake.
REQ-011 SHALL have mem_addr_o  output  XLEN, mem_wdata_o  output  XLEN, mem_wmask_o  output  XLEN/8, mem_wen_o  output  1  shared memory request fields.
REQ-012 SHALL have mem_resp_valid_i  input  1 and mem_rdata_i  input  XLEN  memory response.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP.
REQ-014 IDLE: ready asserted only to the selected requester, combinationally; at most one of ifu_req_ready_o/lsu_req_ready_o high in any cycle.
REQ-015 Selection: single valid requester wins; both valid -> requester not granted last (last_grant register), round-robin.
REQ-016 On accepted handshake in IDLE: latch addr/wdata/wmask/wen (IFU: wen=0, wmask=0) and owner into registers; next state ISSUE.
REQ-017 ISSUE: mem_req_valid_o=1, mem_* driven only from latched registers, stable until mem_req_ready_i; on ready -> WAIT_RESP, same cycle update last_grant to owner.
REQ-018 WAIT_RESP: on mem_resp_valid_i, owner's resp_valid_o=1 for exactly that cycle, rdata_o = mem_rdata_i (combinational pass-through); -> IDLE.
REQ-019 Minimum latency: request accepted cycle N, mem_req_valid_o cycle N+1, response earliest cycle N+2; next acceptance earliest cycle N+3.
REQ-020 Every transaction (including stores) SHALL complete only via mem_resp_valid_i; stores return rdata ignored by LSU.
REQ-021 mem_resp_valid_i in IDLE or ISSUE SHALL be ignored; no resp_valid_o asserted.
REQ-022 Non-owner resp_valid_o SHALL be 0 at all times; rdata_o of non-owner SHALL be 0.
REQ-023 A requester dropping valid before handshake SHALL not be granted; no request is ever lost once accepted.
REQ-024 mem_req_valid_o SHALL be 0 in IDLE and WAIT_RESP.

Reset
REQ-025 rst_i assertion at any time SHALL force IDLE, last_grant=IFU, latched registers=0, all valid/ready outputs 0 while asserted.
REQ-026 Reset mid-transaction SHALL abandon it; a later stale mem_resp_valid_i is ignored per REQ-021.
REQ-027 First cycle after reset release with both requesting SHALL grant LSU.

Structure
REQ-028 liang_pkg SHALL hold XLEN, arb_state_e (IDLE/ISSUE/WAIT_RESP) and mem_req_t struct (addr, wdata, wmask, wen).
REQ-029 Two-way round-robin selection SHALL be sub-module rr_arb2 (inputs req[1:0], last_grant; output grant one-hot); rest in mem_arbiter.

Verification
REQ-030 IFU only, addr 0x80000000, mem ready immediate, resp rdata 0x00100073 one cycle later -> ifu_resp_valid_o with 0x00100073 at N+2, lsu_resp_valid_o never high.
REQ-031 Both valid from reset release, LSU store 0x80001000 data 0xDEADBEEF mask 0xF -> LSU granted first, mem_wen_o=1; IFU granted next, then alternation over 4 conflicts (L,I,L,I).
REQ-032 mem_req_ready_i held low 5 cycles in ISSUE while inputs change -> mem_addr_o/wdata/wmask/wen constant, mem_req_valid_o high all 5 cycles.
REQ-033 Spurious mem_resp_valid_i in IDLE with rdata 0x12345678 -> no resp_valid_o, FSM stays IDLE.
REQ-034 rst_i pulsed in WAIT_RESP, then mem_resp_valid_i -> no resp_valid_o; outputs 0 during reset; LSU granted first on next conflict.
REQ-035 Assertion check all runs: ready one-hot-or-zero; resp_valid one-hot-or-zero; one response per accepted request.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package liang_pkg;

   // Data and address width of the core memory interfaces.
   localparam int XLEN = 32;

   // Arbiter control states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_e;

   // Requester identity; also the encoding of the round-robin history bit.
   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } owner_e;

   // One latched memory request as presented on the shared port.
   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wmask;
      logic              wen;
   } mem_req_t;

endpackage : liang_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. Bit 0 is the IFU, bit 1 the LSU.
// A lone requester always wins; on a conflict the requester that was
// not granted last time wins.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,   // 1: LSU was granted last, 0: IFU
   output logic [1:0] grant_o
);

   // One-hot (or zero) grant from the current requests and the history bit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      grant_o = 2'b00;
      unique case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Arbitrates the IFU and LSU onto a single memory port with one
// transaction in flight. A request is accepted in IDLE, presented on the
// memory port in ISSUE until the memory accepts it, and completed in
// WAIT_RESP when the memory returns its response. The XLEN parameter must
// match liang_pkg::XLEN because the latched request uses mem_req_t.
module mem_arbiter #(
   parameter int XLEN = liang_pkg::XLEN
) (
   input  logic              clk_i,
   input  logic              rst_i,

   // Instruction fetch requester (reads only)
   input  logic              ifu_req_valid_i,
   output logic              ifu_req_ready_o,
   input  logic [XLEN-1:0]   ifu_addr_i,
   output logic              ifu_resp_valid_o,
   output logic [XLEN-1:0]   ifu_rdata_o,

   // Load/store requester
   input  logic              lsu_req_valid_i,
   output logic              lsu_req_ready_o,
   input  logic [XLEN-1:0]   lsu_addr_i,
   input  logic [XLEN-1:0]   lsu_wdata_i,
   input  logic [XLEN/8-1:0] lsu_wmask_i,
   input  logic              lsu_wen_i,
   output logic              lsu_resp_valid_o,
   output logic [XLEN-1:0]   lsu_rdata_o,

   // Shared memory port
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [XLEN/8-1:0] mem_wmask_o,
   output logic              mem_wen_o,
   input  logic              mem_resp_valid_i,
   input  logic [XLEN-1:0]   mem_rdata_i
);

   import liang_pkg::*;

   arb_state_e state_q, state_d;
   mem_req_t   req_q, req_d;
   owner_e     owner_q, owner_d;
   owner_e     last_grant_q, last_grant_d;

   logic [1:0] grant;
   logic       ifu_accept;
   logic       lsu_accept;

   rr_arb2 u_rr_arb2 (
      .req_i        ({lsu_req_valid_i, ifu_req_valid_i}),
      .last_grant_i (last_grant_q == OWNER_LSU),
      .grant_o      (grant)
   );

   // A handshake completes only when the requester sees its own ready.
   assign ifu_accept = ifu_req_valid_i && ifu_req_ready_o;
   assign lsu_accept = lsu_req_valid_i && lsu_req_ready_o;

   // The memory port only ever reflects the latched request, so it stays
   // stable while the memory stalls regardless of what the requesters do.
   assign mem_addr_o  = req_q.addr;
   assign mem_wdata_o = req_q.wdata;
   assign mem_wmask_o = req_q.wmask;
   assign mem_wen_o   = req_q.wen;

   // State register plus latched request, owner and round-robin history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: the latched request is reset along with the control state so
      // the memory port shows zeros, not stale data, after a reset.
      if (rst_i) begin
         state_q      <= IDLE;
         req_q        <= '0;
         owner_q      <= OWNER_IFU;
         last_grant_q <= OWNER_IFU;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so
         // every register samples the pre-edge values of the others.
         state_q      <= state_d;
         req_q        <= req_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state logic: accept in IDLE, hand off in ISSUE, complete in WAIT_RESP.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;

      unique case (state_q)
         IDLE: begin
            if (lsu_accept) begin
               req_d.addr  = lsu_addr_i;
               req_d.wdata = lsu_wdata_i;
               req_d.wmask = lsu_wmask_i;
               req_d.wen   = lsu_wen_i;
               owner_d     = OWNER_LSU;
               state_d     = ISSUE;
            end else if (ifu_accept) begin
               req_d.addr  = ifu_addr_i;
               req_d.wdata = '0;
               req_d.wmask = '0;
               req_d.wen   = 1'b0;
               owner_d     = OWNER_IFU;
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            // History advances when the memory takes the request, so the
            // next conflict in IDLE favours the other requester.
            if (mem_req_ready_i) begin
               last_grant_d = owner_q;
               state_d      = WAIT_RESP;
            end
         end

         WAIT_RESP: begin
            if (mem_resp_valid_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state; responses go to the owner only.
   always_comb begin
      ifu_req_ready_o  = 1'b0;
      lsu_req_ready_o  = 1'b0;
      mem_req_valid_o  = 1'b0;
      ifu_resp_valid_o = 1'b0;
      lsu_resp_valid_o = 1'b0;
      ifu_rdata_o      = '0;
      lsu_rdata_o      = '0;

      unique case (state_q)
         IDLE: begin
            // Ready is combinational from valid, so it is also gated by the
            // reset itself to keep every handshake output low during reset.
            if (!rst_i) begin
               ifu_req_ready_o = grant[0];
               lsu_req_ready_o = grant[1];
            end
         end

         ISSUE: begin
            mem_req_valid_o = 1'b1;
         end

         WAIT_RESP: begin
            if (mem_resp_valid_i) begin
               if (owner_q == OWNER_LSU) begin
                  lsu_resp_valid_o = 1'b1;
                  lsu_rdata_o      = mem_rdata_i;
               end else begin
                  ifu_resp_valid_o = 1'b1;
                  ifu_rdata_o      = mem_rdata_i;
               end
            end
         end

         default: ;
      endcase
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are compared 1 time unit later; a negedge
// monitor tracks handshake invariants across the whole run.
module tb_mem_arbiter;

   localparam int XLEN = 32;

   logic              clk_i;
   logic              rst_i;
   logic              ifu_req_valid_i;
   logic              ifu_req_ready_o;
   logic [XLEN-1:0]   ifu_addr_i;
   logic              ifu_resp_valid_o;
   logic [XLEN-1:0]   ifu_rdata_o;
   logic              lsu_req_valid_i;
   logic              lsu_req_ready_o;
   logic [XLEN-1:0]   lsu_addr_i;
   logic [XLEN-1:0]   lsu_wdata_i;
   logic [XLEN/8-1:0] lsu_wmask_i;
   logic              lsu_wen_i;
   logic              lsu_resp_valid_o;
   logic [XLEN-1:0]   lsu_rdata_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [XLEN-1:0]   mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic [XLEN/8-1:0] mem_wmask_o;
   logic              mem_wen_o;
   logic              mem_resp_valid_i;
   logic [XLEN-1:0]   mem_rdata_i;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_arbiter #(.XLEN(XLEN)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ifu_req_valid_i  (ifu_req_valid_i),
      .ifu_req_ready_o  (ifu_req_ready_o),
      .ifu_addr_i       (ifu_addr_i),
      .ifu_resp_valid_o (ifu_resp_valid_o),
      .ifu_rdata_o      (ifu_rdata_o),
      .lsu_req_valid_i  (lsu_req_valid_i),
      .lsu_req_ready_o  (lsu_req_ready_o),
      .lsu_addr_i       (lsu_addr_i),
      .lsu_wdata_i      (lsu_wdata_i),
      .lsu_wmask_i      (lsu_wmask_i),
      .lsu_wen_i        (lsu_wen_i),
      .lsu_resp_valid_o (lsu_resp_valid_o),
      .lsu_rdata_o      (lsu_rdata_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_wmask_o      (mem_wmask_o),
      .mem_wen_o        (mem_wen_o),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_rdata_i      (mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Invariant monitor: one-hot-or-zero ready/response, and exactly one
   // response per accepted request (outstanding count cleared by reset).
   logic any_accept;
   logic any_resp;
   int   viol         = 0;
   int   outstanding  = 0;
   int   lsu_resp_cnt = 0;

   assign any_accept = (ifu_req_valid_i && ifu_req_ready_o) ||
                       (lsu_req_valid_i && lsu_req_ready_o);
   assign any_resp   = ifu_resp_valid_o || lsu_resp_valid_o;

   always @(negedge clk_i) begin
      viol <= viol
              + int'(ifu_req_ready_o && lsu_req_ready_o)
              + int'(ifu_resp_valid_o && lsu_resp_valid_o)
              + int'(!rst_i && any_resp && outstanding == 0)
              + int'(outstanding > 1);
      if (rst_i) outstanding <= 0;
      else       outstanding <= outstanding + int'(any_accept) - int'(any_resp);
      lsu_resp_cnt <= lsu_resp_cnt + int'(lsu_resp_valid_o);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i            = 1'b1;
      ifu_req_valid_i  = 1'b1;
      lsu_req_valid_i  = 1'b1;
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'hA5A5_A5A5;
      tick();
      tick();
      #1;
      tests_run++; if (ifu_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ifu_ready: got %b want 0", ifu_req_ready_o); end
      tests_run++; if (lsu_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_lsu_ready: got %b want 0", lsu_req_ready_o); end
      tests_run++; if (mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid_o); end
      tests_run++; if ({ifu_resp_valid_o, lsu_resp_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL reset_resp_valid: got %b want 00", {ifu_resp_valid_o, lsu_resp_valid_o}); end
      tests_run++; if (mem_addr_o !== 32'h0 || mem_wen_o !== 1'b0) begin tests_failed++; $display("FAIL reset_latched: addr %h wen %b want 0/0", mem_addr_o, mem_wen_o); end
      ifu_req_valid_i  = 1'b0;
      lsu_req_valid_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;
      rst_i            = 1'b0;
   endtask

   task automatic test_ifu_read();
      int lsu_cnt0;
      lsu_cnt0 = lsu_resp_cnt;
      tick();                                    // cycle N
      ifu_req_valid_i = 1'b1;
      ifu_addr_i      = 32'h8000_0000;
      mem_req_ready_i = 1'b1;
      #1;
      tests_run++; if (ifu_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ifu_ready: got %b want 1", ifu_req_ready_o); end
      tests_run++; if (lsu_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ifu_lsu_ready: got %b want 0", lsu_req_ready_o); end
      tests_run++; if (mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL idle_mem_valid: got %b want 0", mem_req_valid_o); end
      tick();                                    // cycle N+1
      ifu_req_valid_i = 1'b0;
      #1;
      tests_run++; if (mem_req_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ifu_mem_valid: got %b want 1", mem_req_valid_o); end
      tests_run++; if (mem_addr_o !== 32'h8000_0000) begin tests_failed++; $display("FAIL ifu_mem_addr: got %h want 80000000", mem_addr_o); end
      tests_run++; if (mem_wen_o !== 1'b0 || mem_wmask_o !== 4'h0) begin tests_failed++; $display("FAIL ifu_mem_wen_wmask: got %b/%h want 0/0", mem_wen_o, mem_wmask_o); end
      tick();                                    // cycle N+2
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'h0010_0073;
      #1;
      tests_run++; if (mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL wait_mem_valid: got %b want 0", mem_req_valid_o); end
      tests_run++; if (ifu_resp_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ifu_resp_valid: got %b want 1", ifu_resp_valid_o); end
      tests_run++; if (ifu_rdata_o !== 32'h0010_0073) begin tests_failed++; $display("FAIL ifu_rdata: got %h want 00100073", ifu_rdata_o); end
      tests_run++; if (lsu_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL ifu_nonowner_rdata: got %h want 0", lsu_rdata_o); end
      tick();                                    // cycle N+3
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;
      #1;
      tests_run++; if (ifu_resp_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ifu_resp_one_cycle: got %b want 0", ifu_resp_valid_o); end
      tests_run++; if (lsu_resp_cnt !== lsu_cnt0) begin tests_failed++; $display("FAIL ifu_lsu_resp_seen: got %0d lsu responses want 0", lsu_resp_cnt - lsu_cnt0); end
   endtask

   task automatic test_conflict();
      logic exp_lsu;
      tick();
      rst_i           = 1'b1;
      ifu_req_valid_i = 1'b1;
      ifu_addr_i      = 32'h8000_0004;
      lsu_req_valid_i = 1'b1;
      lsu_addr_i      = 32'h8000_1000;
      lsu_wdata_i     = 32'hDEAD_BEEF;
      lsu_wmask_i     = 4'hF;
      lsu_wen_i       = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_lsu = (k % 2 == 0);
         tests_run++; if (lsu_req_ready_o !== exp_lsu || ifu_req_ready_o !== !exp_lsu) begin tests_failed++; $display("FAIL rr_grant_%0d: got lsu/ifu %b%b want %b%b", k, lsu_req_ready_o, ifu_req_ready_o, exp_lsu, !exp_lsu); end
         tick();
         mem_req_ready_i = 1'b1;
         #1;
         tests_run++; if (mem_req_valid_o !== 1'b1 || mem_wen_o !== exp_lsu) begin tests_failed++; $display("FAIL rr_issue_%0d: got valid %b wen %b want 1/%b", k, mem_req_valid_o, mem_wen_o, exp_lsu); end
         tests_run++; if (mem_addr_o !== (exp_lsu ? 32'h8000_1000 : 32'h8000_0004) || mem_wmask_o !== (exp_lsu ? 4'hF : 4'h0)) begin tests_failed++; $display("FAIL rr_fields_%0d: got addr %h mask %h", k, mem_addr_o, mem_wmask_o); end
         if (exp_lsu) begin
            tests_run++; if (mem_wdata_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rr_wdata_%0d: got %h want deadbeef", k, mem_wdata_o); end
         end
         tick();
         mem_req_ready_i  = 1'b0;
         mem_resp_valid_i = 1'b1;
         mem_rdata_i      = 32'h0000_1000 + 32'(k);
         #1;
         tests_run++; if (lsu_resp_valid_o !== exp_lsu || ifu_resp_valid_o !== !exp_lsu) begin tests_failed++; $display("FAIL rr_resp_%0d: got lsu/ifu %b%b want %b%b", k, lsu_resp_valid_o, ifu_resp_valid_o, exp_lsu, !exp_lsu); end
         tests_run++; if ((exp_lsu ? lsu_rdata_o : ifu_rdata_o) !== 32'h0000_1000 + 32'(k) || (exp_lsu ? ifu_rdata_o : lsu_rdata_o) !== 32'h0) begin tests_failed++; $display("FAIL rr_rdata_%0d: got ifu %h lsu %h", k, ifu_rdata_o, lsu_rdata_o); end
         tick();
         mem_resp_valid_i = 1'b0;
         mem_rdata_i      = '0;
         #1;
      end
      ifu_req_valid_i = 1'b0;
      lsu_req_valid_i = 1'b0;
      lsu_wen_i       = 1'b0;
   endtask

   task automatic test_stall();
      tick();
      lsu_req_valid_i = 1'b1;
      lsu_addr_i      = 32'h8000_2000;
      lsu_wdata_i     = 32'hCAFE_F00D;
      lsu_wmask_i     = 4'h3;
      lsu_wen_i       = 1'b1;
      #1;
      tests_run++; if (lsu_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL stall_accept: got %b want 1", lsu_req_ready_o); end
      tick();
      for (int i = 0; i < 5; i++) begin
         lsu_addr_i      = 32'h9000_0000 + 32'(i * 4);
         lsu_wdata_i     = 32'(i) << 8;
         lsu_wmask_i     = 4'(i);
         lsu_wen_i       = 1'(i);
         ifu_req_valid_i = 1'b1;
         ifu_addr_i      = 32'(i);
         #1;
         tests_run++; if (mem_req_valid_o !== 1'b1) begin tests_failed++; $display("FAIL stall_valid_%0d: got %b want 1", i, mem_req_valid_o); end
         tests_run++; if ({mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o} !== {32'h8000_2000, 32'hCAFE_F00D, 4'h3, 1'b1}) begin tests_failed++; $display("FAIL stall_fields_%0d: got %h %h %h %b", i, mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o); end
         tests_run++; if (ifu_req_ready_o !== 1'b0 || lsu_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL stall_ready_%0d: got ifu %b lsu %b want 0/0", i, ifu_req_ready_o, lsu_req_ready_o); end
         tick();
      end
      mem_req_ready_i = 1'b1;
      ifu_req_valid_i = 1'b0;
      lsu_req_valid_i = 1'b0;
      lsu_wen_i       = 1'b0;
      tick();
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'h0;
      #1;
      tests_run++; if (lsu_resp_valid_o !== 1'b1 || ifu_resp_valid_o !== 1'b0) begin tests_failed++; $display("FAIL stall_store_resp: got lsu %b ifu %b want 1/0", lsu_resp_valid_o, ifu_resp_valid_o); end
      tick();
      mem_resp_valid_i = 1'b0;
   endtask

   task automatic test_spurious();
      tick();
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'h1234_5678;
      #1;
      tests_run++; if ({ifu_resp_valid_o, lsu_resp_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL spurious_resp_valid: got %b want 00", {ifu_resp_valid_o, lsu_resp_valid_o}); end
      tests_run++; if (ifu_rdata_o !== 32'h0 || lsu_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL spurious_rdata: got ifu %h lsu %h want 0/0", ifu_rdata_o, lsu_rdata_o); end
      tick();
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;
      ifu_req_valid_i  = 1'b1;
      ifu_addr_i       = 32'h8000_0100;
      #1;
      tests_run++; if (ifu_req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL spurious_still_idle: got ready %b mem_valid %b want 1/0", ifu_req_ready_o, mem_req_valid_o); end
      ifu_req_valid_i = 1'b0;                    // withdrawn before the edge
      tick();
      #1;
      tests_run++; if (mem_req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL dropped_not_granted: got mem_valid %b want 0", mem_req_valid_o); end
   endtask

   task automatic test_reset_mid();
      tick();
      lsu_req_valid_i = 1'b1;
      lsu_addr_i      = 32'h8000_3000;
      lsu_wdata_i     = 32'h1122_3344;
      lsu_wmask_i     = 4'hF;
      lsu_wen_i       = 1'b1;
      mem_req_ready_i = 1'b1;
      #1;
      tests_run++; if (lsu_req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_accept: got %b want 1", lsu_req_ready_o); end
      tick();                                    // ISSUE, memory takes it
      lsu_req_valid_i = 1'b0;
      tick();                                    // WAIT_RESP
      mem_req_ready_i = 1'b0;
      rst_i           = 1'b1;
      ifu_req_valid_i = 1'b1;
      lsu_req_valid_i = 1'b1;
      #1;
      tests_run++; if ({ifu_req_ready_o, lsu_req_ready_o, mem_req_valid_o} !== 3'b000) begin tests_failed++; $display("FAIL mid_reset_outputs: got %b want 000", {ifu_req_ready_o, lsu_req_ready_o, mem_req_valid_o}); end
      tests_run++; if (mem_addr_o !== 32'h0 || mem_wen_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_latched: got addr %h wen %b want 0/0", mem_addr_o, mem_wen_o); end
      tick();
      rst_i            = 1'b0;
      ifu_req_valid_i  = 1'b0;
      lsu_req_valid_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'hDEAD_0001;
      #1;
      tests_run++; if ({ifu_resp_valid_o, lsu_resp_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL stale_resp: got %b want 00", {ifu_resp_valid_o, lsu_resp_valid_o}); end
      tick();
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;
      ifu_req_valid_i  = 1'b1;
      lsu_req_valid_i  = 1'b1;
      #1;
      tests_run++; if (lsu_req_ready_o !== 1'b1 || ifu_req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL post_reset_lsu_first: got lsu %b ifu %b want 1/0", lsu_req_ready_o, ifu_req_ready_o); end
      tick();
      ifu_req_valid_i = 1'b0;
      lsu_req_valid_i = 1'b0;
      mem_req_ready_i = 1'b1;
      #1;
      tests_run++; if (mem_addr_o !== 32'h8000_3000 || mem_wdata_o !== 32'h1122_3344) begin tests_failed++; $display("FAIL post_reset_issue: got addr %h data %h", mem_addr_o, mem_wdata_o); end
      tick();
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      #1;
      tests_run++; if (lsu_resp_valid_o !== 1'b1) begin tests_failed++; $display("FAIL post_reset_resp: got %b want 1", lsu_resp_valid_o); end
      tick();
      mem_resp_valid_i = 1'b0;
      lsu_wen_i        = 1'b0;
      tick();
   endtask

   task automatic test_invariants();
      tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL invariants: got %0d violations want 0", viol); end
      tests_run++; if (outstanding !== 0) begin tests_failed++; $display("FAIL outstanding: got %0d want 0", outstanding); end
   endtask

   initial begin
      rst_i            = 1'b1;
      ifu_req_valid_i  = 1'b0;
      ifu_addr_i       = '0;
      lsu_req_valid_i  = 1'b0;
      lsu_addr_i       = '0;
      lsu_wdata_i      = '0;
      lsu_wmask_i      = '0;
      lsu_wen_i        = 1'b0;
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;

      test_reset();
      test_ifu_read();
      test_conflict();
      test_stall();
      test_spurious();
      test_reset_mid();
      test_invariants();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mem_arbiter
